// File: rtl/aeolus_pkg.sv
// Shared constants for the 4-bit datapath controller: widths, opcodes,
// sequencer states and datapath source-mux selects.
package aeolus_pkg;

    localparam int DATA_W  = 4;
    localparam int INSTR_W = 8;
    localparam int PC_W    = 4;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_DECODE  = 2'b01,
        ST_EXECUTE = 2'b10,
        ST_HALT    = 2'b11
    } state_e;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_LDB  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_OUT  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_JZ   = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] SRC_IMM = 2'b00;
    localparam logic [1:0] SRC_ADD = 2'b01;
    localparam logic [1:0] SRC_SUB = 2'b10;
    localparam logic [1:0] SRC_A   = 2'b11;

endpackage

// File: rtl/instruction_sequencer_if.sv
// Bundle between the sequencer, the program ROM and the datapath registers.
// The master side is the sequencer; the slave side is the ROM/datapath.
interface instruction_sequencer_if;
    import aeolus_pkg::*;

    logic [INSTR_W-1:0] ROM_DATA;
    logic               ZERO;
    logic [PC_W-1:0]    ROM_ADDR;
    logic [DATA_W-1:0]  IMM;
    logic [1:0]         SRC_SEL;
    logic               LOAD_A;
    logic               LOAD_B;
    logic               LOAD_OUT;
    logic               HALTED;
    logic [1:0]         STATE;

    modport master (
        input  ROM_DATA, ZERO,
        output ROM_ADDR, IMM, SRC_SEL, LOAD_A, LOAD_B, LOAD_OUT, HALTED, STATE
    );

    modport slave (
        output ROM_DATA, ZERO,
        input  ROM_ADDR, IMM, SRC_SEL, LOAD_A, LOAD_B, LOAD_OUT, HALTED, STATE
    );

endinterface

// File: rtl/program_counter.sv
// 4-bit program counter. A jump load wins over the fetch increment, and the
// counter wraps naturally from 15 back to 0.
module program_counter
    import aeolus_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET,
    input  logic            ENABLE,
    input  logic            INC,
    input  logic            LOAD,
    input  logic [PC_W-1:0] LOAD_VAL,
    output logic [PC_W-1:0] PC
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Next PC: hold when stalled, otherwise jump target or increment.
    always_comb begin
        pc_d = pc_q;
        if (ENABLE) begin
            if (LOAD) begin
                pc_d = LOAD_VAL;
            end else if (INC) begin
                pc_d = pc_q + 4'd1;
            end
        end
    end

    // PC register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC = pc_q;

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute controller. Strobes and source select are decoded
// only from the registered state and IR, so they are glitch-free with respect
// to ROM_DATA and ZERO; ENABLE only masks the strobes during a stall.
module instruction_sequencer
    import aeolus_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    ENABLE,
    instruction_sequencer_if.master bus
);

    state_e             state_q;
    state_e             state_d;
    logic [INSTR_W-1:0] ir_q;
    logic [INSTR_W-1:0] ir_d;
    logic [3:0]         opcode;
    logic [PC_W-1:0]    pc;
    logic               pc_inc;
    logic               pc_load;
    logic               load_a;
    logic               load_b;
    logic               load_out;
    logic [1:0]         src_sel;

    assign opcode  = ir_q[7:4];
    assign pc_inc  = (state_q == ST_FETCH);
    assign pc_load = (state_q == ST_EXECUTE) &&
                     ((opcode == OP_JMP) || ((opcode == OP_JZ) && bus.ZERO));

    program_counter u_pc (
        .CLK      (CLK),
        .RESET    (RESET),
        .ENABLE   (ENABLE),
        .INC      (pc_inc),
        .LOAD     (pc_load),
        .LOAD_VAL (ir_q[3:0]),
        .PC       (pc)
    );

    // Next state and instruction register; everything holds while stalled.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        if (ENABLE) begin
            case (state_q)
                ST_FETCH: begin
                    ir_d    = bus.ROM_DATA;
                    state_d = ST_DECODE;
                end
                ST_DECODE:  state_d = ST_EXECUTE;
                ST_EXECUTE: state_d = (opcode == OP_HALT) ? ST_HALT : ST_FETCH;
                ST_HALT:    state_d = ST_HALT;
                default:    state_d = ST_FETCH;
            endcase
        end
    end

    // State and IR registers; reset overrides ENABLE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Opcode decode, active only in EXECUTE; undefined opcodes act as NOP.
    always_comb begin
        load_a   = 1'b0;
        load_b   = 1'b0;
        load_out = 1'b0;
        src_sel  = SRC_IMM;
        if (state_q == ST_EXECUTE) begin
            case (opcode)
                OP_LDA: load_a = 1'b1;
                OP_LDB: load_b = 1'b1;
                OP_ADD: begin
                    load_a  = 1'b1;
                    src_sel = SRC_ADD;
                end
                OP_SUB: begin
                    load_a  = 1'b1;
                    src_sel = SRC_SUB;
                end
                OP_OUT: begin
                    load_out = 1'b1;
                    src_sel  = SRC_A;
                end
                default: ;
            endcase
        end
    end

    assign bus.ROM_ADDR = pc;
    assign bus.IMM      = ir_q[3:0];
    assign bus.SRC_SEL  = src_sel;
    assign bus.LOAD_A   = load_a & ENABLE;
    assign bus.LOAD_B   = load_b & ENABLE;
    assign bus.LOAD_OUT = load_out & ENABLE;
    assign bus.HALTED   = (state_q == ST_HALT);
    assign bus.STATE    = state_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: a behavioural model predicts every cycle's
// outputs into a scoreboard queue, plus directed checks at key cycles.
module tb_instruction_sequencer;
    import aeolus_pkg::*;

    logic CLK = 1'b0;
    logic RESET;
    logic ENABLE;
    logic zero_in;
    logic [7:0] rom [16];

    instruction_sequencer_if bus();

    instruction_sequencer dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .ENABLE (ENABLE),
        .bus    (bus)
    );

    assign bus.ROM_DATA = rom[bus.ROM_ADDR];
    assign bus.ZERO     = zero_in;

    always #5 CLK = ~CLK;

    // Packed view: {ROM_ADDR, IMM, SRC_SEL, LOAD_A, LOAD_B, LOAD_OUT, HALTED, STATE}
    logic [15:0] dut_vec;
    assign dut_vec = {bus.ROM_ADDR, bus.IMM, bus.SRC_SEL, bus.LOAD_A,
                      bus.LOAD_B, bus.LOAD_OUT, bus.HALTED, bus.STATE};

    int tests_run    = 0;
    int tests_failed = 0;
    logic [15:0] exp_q [$];
    string phase = "init";

    logic [1:0] m_state;
    logic [3:0] m_pc;
    logic [7:0] m_ir;

    // Compare one observed value against its expectation.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Expected outputs for the current model state.
    function automatic logic [15:0] model_outputs(input logic en);
        logic       la, lb, lo;
        logic [1:0] src;
        la = 1'b0; lb = 1'b0; lo = 1'b0; src = 2'b00;
        if (m_state == 2'b10) begin
            case (m_ir[7:4])
                4'h1: la = 1'b1;
                4'h2: lb = 1'b1;
                4'h3: begin la = 1'b1; src = 2'b01; end
                4'h4: begin la = 1'b1; src = 2'b10; end
                4'h5: begin lo = 1'b1; src = 2'b11; end
                default: ;
            endcase
        end
        return {m_pc, m_ir[3:0], src, la & en, lb & en, lo & en,
                (m_state == 2'b11), m_state};
    endfunction

    // Advance the model by one clock edge.
    task automatic model_step(input logic rst, input logic en, input logic z);
        if (rst) begin
            m_state = 2'b00; m_pc = 4'h0; m_ir = 8'h00;
        end else if (en) begin
            case (m_state)
                2'b00: begin m_ir = rom[m_pc]; m_pc = m_pc + 4'd1; m_state = 2'b01; end
                2'b01: m_state = 2'b10;
                2'b10: begin
                    if (m_ir[7:4] == 4'h6 || (m_ir[7:4] == 4'h7 && z)) m_pc = m_ir[3:0];
                    m_state = (m_ir[7:4] == 4'hF) ? 2'b11 : 2'b00;
                end
                default: ;
            endcase
        end
    endtask

    // Drive one cycle, score it against the model, then cross the edge.
    task automatic applyStimulus(input logic rst, input logic en, input logic z);
        RESET = rst; ENABLE = en; zero_in = z;
        exp_q.push_back(model_outputs(en));
        #1;
        checkOutput({phase, "_cycle"}, dut_vec, exp_q.pop_front());
        @(posedge CLK);
        model_step(rst, en, z);
        #1;
    endtask

    task automatic load_rom(input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input logic [7:0] w3,
                            input logic [7:0] w4);
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3; rom[4] = w4;
    endtask

    task automatic reset_dut();
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        int pulses;
        load_rom(8'h19, 8'h23, 8'h30, 8'h50, 8'hF0);
        RESET = 1'b1; ENABLE = 1'b1; zero_in = 1'b0;
        @(posedge CLK);
        model_step(1'b1, 1'b1, 1'b0);
        #1;

        // Reset values and the basic program
        phase = "prog";
        reset_dut();
        checkOutput("reset_values", dut_vec, 16'h0000);
        for (int c = 1; c <= 20; c++) begin
            if (c == 1) checkOutput("prog_c1_state", 16'(bus.STATE), 16'h0);
            if (c == 2) checkOutput("prog_c2_state", 16'(bus.STATE), 16'h1);
            if (c == 3) checkOutput("prog_c3_lda", 16'({bus.STATE, bus.LOAD_A, bus.IMM, bus.SRC_SEL}),
                                    16'({2'b10, 1'b1, 4'h9, 2'b00}));
            if (c == 4) checkOutput("prog_c4_state", 16'(bus.STATE), 16'h0);
            if (c == 6) checkOutput("prog_c6_ldb", 16'({bus.LOAD_B, bus.IMM}), 16'({1'b1, 4'h3}));
            if (c == 9) checkOutput("prog_c9_add", 16'({bus.LOAD_A, bus.SRC_SEL}), 16'({1'b1, 2'b01}));
            if (c == 12) checkOutput("prog_c12_out", 16'({bus.LOAD_OUT, bus.SRC_SEL}), 16'({1'b1, 2'b11}));
            if (c >= 16) checkOutput("prog_halted", 16'({bus.HALTED, bus.LOAD_A, bus.LOAD_B, bus.LOAD_OUT}),
                                     16'({1'b1, 3'b000}));
            applyStimulus(1'b0, 1'b1, 1'b0);
        end

        // Reset out of HALT
        phase = "halt_reset";
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("halt_reset_state", 16'({bus.ROM_ADDR, bus.STATE, bus.HALTED}), 16'h0000);

        // JZ with both ZERO values, ZERO inverted during DECODE
        for (int zv = 1; zv >= 0; zv--) begin
            phase = (zv == 1) ? "jz_taken" : "jz_not_taken";
            load_rom(8'h00, 8'h00, 8'h00, 8'h00, 8'h7A);
            reset_dut();
            for (int c = 1; c <= 15; c++)
                applyStimulus(1'b0, 1'b1, (c == 15) ? 1'(zv) : ~1'(zv));
            checkOutput({phase, "_addr"}, 16'(bus.ROM_ADDR), (zv == 1) ? 16'hA : 16'h5);
        end

        // Stall during DECODE of LDA 7
        phase = "stall";
        load_rom(8'h17, 8'h00, 8'h00, 8'h00, 8'h00);
        reset_dut();
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("stall_frozen", 16'({bus.ROM_ADDR, bus.STATE, bus.LOAD_A}),
                        16'({4'h1, 2'b01, 1'b0}));
        end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            if (i == 0) checkOutput("stall_resume_lda", 16'({bus.STATE, bus.LOAD_A, bus.IMM}),
                                    16'({2'b10, 1'b1, 4'h7}));
            pulses += int'(bus.LOAD_A);
        end
        checkOutput("stall_pulse_count", 16'(pulses), 16'd1);

        // Sixteen NOPs: PC wraps from 15 to 0
        phase = "wrap";
        load_rom(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        reset_dut();
        for (int c = 1; c <= 52; c++) begin
            if (c == 46) checkOutput("wrap_pc15", 16'(bus.ROM_ADDR), 16'hF);
            if (c == 49) checkOutput("wrap_pc0", 16'(bus.ROM_ADDR), 16'h0);
            applyStimulus(1'b0, 1'b1, 1'b0);
        end

        // JMP to itself at address 3
        phase = "self_jmp";
        load_rom(8'h00, 8'h00, 8'h00, 8'h63, 8'h00);
        reset_dut();
        for (int c = 1; c <= 40; c++) begin
            if (c >= 13 && (c % 3) == 1) checkOutput("self_jmp_addr", 16'(bus.ROM_ADDR), 16'h3);
            applyStimulus(1'b0, 1'b1, 1'b0);
        end

        // Reset asserted during EXECUTE of ADD
        phase = "exec_reset";
        load_rom(8'h30, 8'h00, 8'h00, 8'h00, 8'h00);
        reset_dut();
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("exec_reset_add", 16'({bus.LOAD_A, bus.SRC_SEL}), 16'({1'b1, 2'b01}));
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("exec_reset_state", 16'({bus.ROM_ADDR, bus.STATE, bus.HALTED}), 16'h0000);

        // Reset asserted while halted
        phase = "halted_reset";
        load_rom(8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);
        reset_dut();
        for (int c = 1; c <= 6; c++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("halted_before_reset", 16'(bus.HALTED), 16'h1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("halted_reset_state", 16'({bus.ROM_ADDR, bus.STATE, bus.HALTED}), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
